sram_jtag_arbiter: RTL and testbench



---
 rtl/sram_jtag_arbiter_pkg.sv | 29 ++
 rtl/sram_jtag_arbiter_if.sv | 53 +++++
 rtl/sram_cycle_timer.sv | 26 ++
 rtl/sram_jtag_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_jtag_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_jtag_arbiter_pkg.sv
// Shared types for the SRAM / USB-JTAG arbiter: FSM states, idle strobe set,
// and the width of the CPU strobe wait counter.
package sram_arb_pkg;

  localparam int WAIT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_SETUP,
    ST_CPU_STROBE,
    ST_CPU_DONE,
    ST_RECOVER,
    ST_HELD,
    ST_RELEASE
  } arb_state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
    logic dq_oe;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                      ub_n: 1'b1, lb_n: 1'b1, dq_oe: 1'b0};

endpackage

// File: rtl/sram_jtag_arbiter_if.sv
// Bundles the CPU bus, the JTAG decoder SRAM port and the board SRAM pins.
// The slave modport is the arbiter's view; master is everything around it.
interface sram_jtag_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [1:0]        cpu_be_n;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              hold;
  logic              hlda;
  logic              jtag_sel;
  logic [ADDR_W-1:0] j_addr;
  logic [DATA_W-1:0] j_wdata;
  logic              j_we_n;
  logic              j_oe_n;
  logic [DATA_W-1:0] j_rdata;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_q;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_ub_n;
  logic              sram_lb_n;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be_n,
    input  cpu_rdata, cpu_ack,
    output hold, jtag_sel, j_addr, j_wdata, j_we_n, j_oe_n,
    input  hlda, j_rdata,
    input  sram_addr, sram_dq, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
    output sram_q
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be_n,
    output cpu_rdata, cpu_ack,
    input  hold, jtag_sel, j_addr, j_wdata, j_we_n, j_oe_n,
    output hlda, j_rdata,
    output sram_addr, sram_dq, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
    input  sram_q
  );

endinterface

// File: rtl/sram_cycle_timer.sv
// Loadable down-counter timing the CPU strobe phase; last is high once the
// count has run down to zero.
module sram_cycle_timer
  import sram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  output logic              last
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - WAIT_W'(1);
  end

  assign last = (count == '0);

endmodule

// File: rtl/sram_jtag_arbiter.sv
// Owns the SRAM pins: runs timed single-word CPU cycles, or hands the pins to
// the JTAG decoder through HOLD/HLDA and passes its strobes straight through.
module sram_jtag_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input logic             clk,
  input logic             rst_n,
  sram_jtag_arbiter_if.slave bus
);

  arb_state_t        state, next_state;
  logic              timer_load, timer_last;
  logic              cap_we, we_d;
  logic [1:0]        cap_be_n, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_q, dq_d, rdata_q;
  sram_ctl_t         ctl_q, ctl_d;
  logic              ack_q, hlda_q;
  logic              jtag_on;

  sram_cycle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (WAIT_W'(WAIT_CYC)),
    .last     (timer_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // HOLD wins over a simultaneous CPU request, but never aborts a CPU cycle
  // already under way.
  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.hold)
          next_state = ST_HELD;
        else if (bus.cpu_req)
          next_state = ST_CPU_SETUP;
      end
      ST_CPU_SETUP: begin
        next_state = ST_CPU_STROBE;
        timer_load = 1'b1;
      end
      ST_CPU_STROBE: if (timer_last) next_state = ST_CPU_DONE;
      ST_CPU_DONE:   next_state = ST_RECOVER;
      ST_RECOVER:    next_state = ST_IDLE;
      ST_HELD:       if (!bus.hold) next_state = ST_RELEASE;
      ST_RELEASE:    next_state = ST_IDLE;
      default:       next_state = ST_IDLE;
    endcase
  end

  // CPU strobes are decoded from the upcoming state and registered, so the
  // pins change cleanly on the clock edge.
  always_comb begin
    ctl_d  = SRAM_IDLE;
    addr_d = addr_q;
    dq_d   = dq_q;
    we_d   = cap_we;
    be_d   = cap_be_n;
    if (state == ST_IDLE && next_state == ST_CPU_SETUP) begin
      addr_d = bus.cpu_addr;
      dq_d   = bus.cpu_wdata;
      we_d   = bus.cpu_we;
      be_d   = bus.cpu_be_n;
    end
    case (next_state)
      ST_CPU_SETUP, ST_CPU_STROBE, ST_CPU_DONE: begin
        ctl_d.ce_n  = 1'b0;
        ctl_d.ub_n  = be_d[1];
        ctl_d.lb_n  = be_d[0];
        ctl_d.dq_oe = we_d;
        if (next_state == ST_CPU_STROBE)
          ctl_d.we_n = ~we_d;
        if (next_state != ST_CPU_DONE)
          ctl_d.oe_n = we_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we   <= 1'b0;
      cap_be_n <= 2'b11;
      addr_q   <= '0;
      dq_q     <= '0;
      ctl_q    <= SRAM_IDLE;
      ack_q    <= 1'b0;
      hlda_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cap_we   <= we_d;
      cap_be_n <= be_d;
      addr_q   <= addr_d;
      dq_q     <= dq_d;
      ctl_q    <= ctl_d;
      ack_q    <= (next_state == ST_CPU_DONE);
      hlda_q   <= (next_state == ST_HELD);
      if (state == ST_CPU_STROBE && timer_last && !cap_we)
        rdata_q <= bus.sram_q;
    end
  end

  // The decoder's strobes bypass the registers so its own timing is kept.
  assign jtag_on = (state == ST_HELD) && bus.jtag_sel;

  assign bus.sram_addr  = jtag_on ? bus.j_addr  : addr_q;
  assign bus.sram_dq    = jtag_on ? bus.j_wdata : dq_q;
  assign bus.sram_ce_n  = jtag_on ? 1'b0        : ctl_q.ce_n;
  assign bus.sram_oe_n  = jtag_on ? bus.j_oe_n  : ctl_q.oe_n;
  assign bus.sram_we_n  = jtag_on ? bus.j_we_n  : ctl_q.we_n;
  assign bus.sram_ub_n  = jtag_on ? 1'b0        : ctl_q.ub_n;
  assign bus.sram_lb_n  = jtag_on ? 1'b0        : ctl_q.lb_n;
  assign bus.sram_dq_oe = jtag_on ? ~bus.j_we_n : ctl_q.dq_oe;

  assign bus.j_rdata   = bus.sram_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ack   = ack_q;
  assign bus.hlda      = hlda_q;

endmodule

// File: tb/tb_sram_jtag_arbiter.sv
// Self-checking bench: table-driven and random CPU accesses against a
// byte-lane memory model, plus HOLD/JTAG and mid-cycle reset sequences.
module tb_sram_jtag_arbiter;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int W      = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   check_count = 0;
  int   pass_count  = 0;

  always #5 clk = ~clk;

  sram_jtag_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_jtag_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Board SRAM device: byte-lane writes on a clock edge with WE_N low, async reads.
  logic [15:0] dev_mem [0:(1<<18)-1] = '{default: 16'h0};

  always @(posedge clk) begin
    if (!bus.sram_ce_n && !bus.sram_we_n) begin
      if (!bus.sram_ub_n) dev_mem[bus.sram_addr][15:8] <= bus.sram_dq[15:8];
      if (!bus.sram_lb_n) dev_mem[bus.sram_addr][7:0]  <= bus.sram_dq[7:0];
    end
  end

  assign bus.sram_q = (!bus.sram_ce_n && !bus.sram_oe_n && !bus.sram_dq_oe)
                      ? dev_mem[bus.sram_addr] : 16'hDEAD;

  // Reference: what each word should hold after the CPU/JTAG writes issued so far.
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_read(input logic [17:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 16'h0000;
  endfunction

  function automatic void ref_write(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be_n);
    logic [15:0] cur;
    cur = ref_read(a);
    if (!be_n[1]) cur[15:8] = d[15:8];
    if (!be_n[0]) cur[7:0]  = d[7:0];
    ref_mem[int'(a)] = cur;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_strobes"},
                 {26'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n, bus.sram_dq_oe},
                 32'h3E);
    check_output({tag, "_addr"}, 32'(bus.sram_addr), 32'h0);
    check_output({tag, "_dq"}, 32'(bus.sram_dq), 32'h0);
    check_output({tag, "_hlda_ack"}, {30'd0, bus.hlda, bus.cpu_ack}, 32'h0);
    check_output({tag, "_rdata"}, 32'(bus.cpu_rdata), 32'h0);
  endtask

  // One CPU access from IDLE: returns latency and per-cycle strobe counts.
  task automatic apply_stimulus(input logic we, input logic [17:0] a, input logic [15:0] d,
                                input logic [1:0] be_n, output logic [15:0] rdata,
                                output int lat, output int wl, output int ol, output int dqc,
                                output logic timed_out);
    lat = 0; wl = 0; ol = 0; dqc = 0; timed_out = 1'b1; rdata = '0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_be_n = be_n;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!bus.sram_we_n) wl++;
      if (!bus.sram_oe_n) ol++;
      if (bus.sram_dq_oe) dqc++;
      if (bus.cpu_ack) begin
        lat = c; rdata = bus.cpu_rdata; timed_out = 1'b0;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [15:0] data;
    logic [1:0]  be_n;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        vecs [10];
  logic [15:0] rd;
  int          lat, wl, ol, dqc, cyc, ack_cyc, hlda_cyc, we_falls;
  logic        to, ack_seen, prev_we_n;

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_be_n = 2'b11;
    bus.hold = 0; bus.jtag_sel = 0; bus.j_addr = '0; bus.j_wdata = '0; bus.j_we_n = 1; bus.j_oe_n = 1;

    vecs[0] = '{1'b1, 18'h12345, 16'hBEEF, 2'b00, 16'h0000};
    vecs[1] = '{1'b0, 18'h12345, 16'h0000, 2'b00, 16'hBEEF};
    vecs[2] = '{1'b1, 18'h12345, 16'h1234, 2'b10, 16'h0000};
    vecs[3] = '{1'b0, 18'h12345, 16'h0000, 2'b00, 16'hBE34};
    vecs[4] = '{1'b1, 18'h00000, 16'hFFFF, 2'b01, 16'h0000};
    vecs[5] = '{1'b0, 18'h00000, 16'h0000, 2'b00, 16'hFF00};
    vecs[6] = '{1'b1, 18'h3FFFF, 16'h5A5A, 2'b00, 16'h0000};
    vecs[7] = '{1'b0, 18'h3FFFF, 16'h0000, 2'b00, 16'h5A5A};
    vecs[8] = '{1'b0, 18'h00001, 16'h0000, 2'b00, 16'h0000};
    vecs[9] = '{1'b0, 18'h12345, 16'h0000, 2'b00, 16'hBE34};

    #2 rst_n = 1'b0;
    #1 check_reset_state("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].be_n, rd, lat, wl, ol, dqc, to);
      check_output($sformatf("vec%0d_timeout", i), 32'(to), 32'h0);
      check_output($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 3));
      if (vecs[i].we) begin
        ref_write(vecs[i].addr, vecs[i].data, vecs[i].be_n);
        check_output($sformatf("vec%0d_we_low", i), 32'(wl), 32'(W + 1));
        check_output($sformatf("vec%0d_dq_oe", i), 32'(dqc), 32'(W + 3));
        check_output($sformatf("vec%0d_oe_low", i), 32'(ol), 32'h0);
      end else begin
        check_output($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
        check_output($sformatf("vec%0d_oe_low", i), 32'(ol), 32'(W + 2));
        check_output($sformatf("vec%0d_dq_oe", i), 32'(dqc), 32'h0);
        check_output($sformatf("vec%0d_we_low", i), 32'(wl), 32'h0);
      end
    end

    for (int i = 0; i < 30; i++) begin
      logic        r_we;
      logic [17:0] r_a;
      logic [15:0] r_d;
      logic [1:0]  r_be;
      r_we = 1'($urandom_range(0, 1));
      r_a  = 18'h00100 + 18'($urandom_range(0, 7));
      r_d  = 16'($urandom);
      r_be = 2'($urandom_range(0, 3));
      apply_stimulus(r_we, r_a, r_d, r_be, rd, lat, wl, ol, dqc, to);
      check_output($sformatf("rand%0d_latency", i), 32'(lat), 32'(W + 3));
      if (r_we)
        ref_write(r_a, r_d, r_be);
      else
        check_output($sformatf("rand%0d_rdata", i), 32'(rd), 32'(ref_read(r_a)));
    end

    // HOLD and CPU request rising together: HOLD wins, CPU waits for release.
    @(negedge clk);
    bus.hold = 1; bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 18'h00300;
    bus.cpu_wdata = 16'h1357; bus.cpu_be_n = 2'b00;
    @(negedge clk);
    check_output("hold_first_hlda", 32'(bus.hlda), 32'h1);
    ack_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.cpu_ack) ack_seen = 1;
    end
    check_output("hold_no_ack", 32'(ack_seen), 32'h0);
    check_output("held_idle_pins", {26'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n,
                 bus.sram_ub_n, bus.sram_lb_n, bus.sram_dq_oe}, 32'h3E);
    bus.hold = 0;
    ack_cyc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) check_output("release_hlda", 32'(bus.hlda), 32'h0);
      if (bus.cpu_ack) begin ack_cyc = c; break; end
    end
    check_output("release_ack_latency", 32'(ack_cyc), 32'(W + 5));
    bus.cpu_req = 0;
    ref_write(18'h00300, 16'h1357, 2'b00);
    @(negedge clk);
    apply_stimulus(1'b0, 18'h00300, 16'h0, 2'b00, rd, lat, wl, ol, dqc, to);
    check_output("post_hold_rdata", 32'(rd), 32'h1357);

    // HOLD raised mid-strobe: the CPU write completes first, then the grant follows.
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 18'h00301; bus.cpu_wdata = 16'h2468; bus.cpu_be_n = 2'b00;
    ack_cyc = 0; hlda_cyc = 0; we_falls = 0; wl = 0; prev_we_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 2) bus.hold = 1;
      if (!bus.sram_we_n) wl++;
      if (prev_we_n && !bus.sram_we_n) we_falls++;
      prev_we_n = bus.sram_we_n;
      if (bus.cpu_ack) begin ack_cyc = c; bus.cpu_req = 0; end
      if (bus.hlda) begin hlda_cyc = c; break; end
    end
    ref_write(18'h00301, 16'h2468, 2'b00);
    check_output("midhold_ack_cycle", 32'(ack_cyc), 32'(W + 3));
    check_output("midhold_hlda_cycle", 32'(hlda_cyc), 32'(W + 6));
    check_output("midhold_we_low", 32'(wl), 32'(W + 1));
    check_output("midhold_we_falls", 32'(we_falls), 32'h1);

    // Granted: JTAG write then read-back through the pass-through path.
    bus.jtag_sel = 1; bus.j_addr = 18'h00010; bus.j_wdata = 16'hA55A; bus.j_we_n = 0; bus.j_oe_n = 1;
    #1;
    check_output("jtag_wr_addr", 32'(bus.sram_addr), 32'h10);
    check_output("jtag_wr_dq", 32'(bus.sram_dq), 32'hA55A);
    check_output("jtag_wr_strobes", {26'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n,
                 bus.sram_ub_n, bus.sram_lb_n, bus.sram_dq_oe}, 32'h11);
    @(negedge clk);
    bus.j_we_n = 1; bus.j_oe_n = 0;
    #1;
    check_output("jtag_rd_data", 32'(bus.j_rdata), 32'hA55A);
    check_output("jtag_rd_dq_oe", 32'(bus.sram_dq_oe), 32'h0);
    ref_write(18'h00010, 16'hA55A, 2'b00);
    bus.jtag_sel = 0; bus.j_oe_n = 1;
    #1;
    check_output("jtag_desel_pins", {26'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n,
                 bus.sram_ub_n, bus.sram_lb_n, bus.sram_dq_oe}, 32'h3E);
    @(negedge clk);
    bus.hold = 0;
    @(negedge clk);
    check_output("jtag_release_hlda", 32'(bus.hlda), 32'h0);
    apply_stimulus(1'b0, 18'h00010, 16'h0, 2'b00, rd, lat, wl, ol, dqc, to);
    check_output("cpu_reads_jtag_word", 32'(rd), 32'hA55A);
    apply_stimulus(1'b0, 18'h00301, 16'h0, 2'b00, rd, lat, wl, ol, dqc, to);
    check_output("cpu_reads_midhold_word", 32'(rd), 32'h2468);

    // Reset pulse in the middle of a CPU write strobe.
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 18'h00200; bus.cpu_wdata = 16'h9999; bus.cpu_be_n = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check_output("pre_reset_we_low", 32'(bus.sram_we_n), 32'h0);
    rst_n = 1'b0;
    #1 check_reset_state("midreset");
    bus.cpu_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.cpu_ack) ack_seen = 1;
    end
    check_output("midreset_no_ack", 32'(ack_seen), 32'h0);
    apply_stimulus(1'b0, 18'h12345, 16'h0, 2'b00, rd, lat, wl, ol, dqc, to);
    check_output("after_reset_latency", 32'(lat), 32'(W + 3));
    check_output("after_reset_rdata", 32'(rd), 32'hBE34);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
